// File: rtl/alu_logic_pkg.sv
// Shared definitions for the chunked bitwise logic unit: op codes and FSM states.
package alu_logic_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_ANDN = 3'b110;
   localparam logic [2:0] OP_NOTA = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational W-bit bitwise operator; one instance is time-shared across all chunks.
import alu_logic_pkg::*;

module logic_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_chunk,
   input  logic [W-1:0] b_chunk,
   input  logic [2:0]   op,
   output logic [W-1:0] y
);

   // NOTE: assign every always_comb output a default before any branch so no path infers a latch.
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a_chunk & b_chunk;
         OP_OR:   y = a_chunk | b_chunk;
         OP_XOR:  y = a_chunk ^ b_chunk;
         OP_NOR:  y = ~(a_chunk | b_chunk);
         OP_NAND: y = ~(a_chunk & b_chunk);
         OP_XNOR: y = ~(a_chunk ^ b_chunk);
         OP_ANDN: y = a_chunk & ~b_chunk;
         OP_NOTA: y = ~a_chunk;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: computes CHUNK bits per clock with a start/busy/done handshake.
import alu_logic_pkg::*;

module seq_logic_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               acc_q, acc_d;

   logic [CHUNK-1:0]   a_chunk, b_chunk, slice_y;

   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   logic_slice #(.W(CHUNK)) u_slice (
      .a_chunk (a_chunk),
      .b_chunk (b_chunk),
      .op      (op_q),
      .y       (slice_y)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
      acc_d    = acc_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               op_d     = op;
               result_d = '0;
               cnt_d    = '0;
               acc_d    = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (cnt_q == CNT_W'(i)) result_d[i*CHUNK +: CHUNK] = slice_y;
            end
            acc_d = acc_q | (|slice_y);
            cnt_d = cnt_q + CNT_W'(1);
            // zero only moves on the final chunk so it keeps the previous verdict through RUN
            if (cnt_q == LAST_CNT) begin
               zero_d  = ~(acc_q | (|slice_y));
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_AND;
         result_q <= '0;
         zero_q   <= 1'b0;
         acc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         acc_q    <= acc_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Self-checking bench for seq_logic_unit: default 8-bit chunking plus a single-chunk instance.
module tb_seq_logic_unit;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, w_start;
   logic [2:0]  op, w_op;
   logic [31:0] a, b, w_a, w_b;
   logic        busy, done, zero, w_busy, w_done, w_zero;
   logic [31:0] result, w_result;

   exp_t exp_q[$];
   exp_t wexp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   seq_logic_unit #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero)
   );

   seq_logic_unit #(.WIDTH(32), .CHUNK(32)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(w_start), .op(w_op), .a(w_a), .b(w_b),
      .busy(w_busy), .done(w_done), .result(w_result), .zero(w_zero)
   );

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x | y);
         3'd4:    return ~(x & y);
         3'd5:    return ~(x ^ y);
         3'd6:    return x & ~y;
         default: return ~x;
      endcase
   endfunction

   function automatic exp_t make_exp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e.res  = model(o, x, y);
      e.zero = (e.res == 32'h0);
      return e;
   endfunction

   // Scoreboards: every done pulse pops one expected result.
   always @(negedge clk) begin : mon_default
      exp_t e;
      if (done === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: done pulsed with no operation outstanding, result=%h", result);
         end else begin
            e = exp_q.pop_front();
            if (result !== e.res) begin
               n_fail++;
               $display("FAIL sb_result: got %h expected %h", result, e.res);
            end
            n_checks++;
            if (zero !== e.zero) begin
               n_fail++;
               $display("FAIL sb_zero: got %b expected %b", zero, e.zero);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_wide
      exp_t e;
      if (w_done === 1'b1) begin
         n_checks++;
         if (wexp_q.size() == 0) begin
            n_fail++;
            $display("FAIL w_done_unexpected: done pulsed with no operation outstanding");
         end else begin
            e = wexp_q.pop_front();
            if (w_result !== e.res) begin
               n_fail++;
               $display("FAIL w_sb_result: got %h expected %h", w_result, e.res);
            end
            n_checks++;
            if (w_zero !== e.zero) begin
               n_fail++;
               $display("FAIL w_sb_zero: got %b expected %b", w_zero, e.zero);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the default instance with cycle-accurate handshake checks.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_res,
                         input logic exp_zero, input logic zero_before);
      start = 1'b1; op = o; a = x; b = y;
      exp_q.push_back(make_exp(o, x, y));
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         op = 3'($urandom); a = $urandom; b = $urandom;
         n_checks++;
         if (busy !== (c <= 4)) begin
            n_fail++;
            $display("FAIL %s_busy_c%0d: got %b expected %b", name, c, busy, (c <= 4));
         end
         n_checks++;
         if (done !== (c == 5)) begin
            n_fail++;
            $display("FAIL %s_done_c%0d: got %b expected %b", name, c, done, (c == 5));
         end
         if (c == 1) begin
            n_checks++;
            if (result !== 32'h0) begin
               n_fail++;
               $display("FAIL %s_cleared: got %h expected 00000000", name, result);
            end
         end
         if (c <= 4) begin
            n_checks++;
            if (zero !== zero_before) begin
               n_fail++;
               $display("FAIL %s_zero_hold_c%0d: got %b expected %b", name, c, zero, zero_before);
            end
         end else begin
            n_checks++;
            if (result !== exp_res) begin
               n_fail++;
               $display("FAIL %s_result: got %h expected %h", name, result, exp_res);
            end
            n_checks++;
            if (zero !== exp_zero) begin
               n_fail++;
               $display("FAIL %s_zero: got %b expected %b", name, zero, exp_zero);
            end
         end
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0; op = 3'd0; a = '0; b = '0;
      w_start = 1'b0; w_op = 3'd0; w_a = '0; w_b = '0;
      tick();
      tick();
      n_checks++;
      if ({busy, done, zero, result} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b zero=%b result=%h expected all 0", busy, done, zero, result);
      end
      n_checks++;
      if ({w_busy, w_done, w_zero, w_result} !== 35'h0) begin
         n_fail++;
         $display("FAIL w_reset_state: busy=%b done=%b zero=%b result=%h expected all 0", w_busy, w_done, w_zero, w_result);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_nor_latency();
      run_op("nor", 3'b011, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 1'b0, 1'b0);
   endtask

   task automatic test_xor_zero();
      run_op("xor", 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         a = $urandom; b = $urandom; op = 3'($urandom);
         tick();
         n_checks++;
         if (zero !== 1'b1 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL xor_hold_c%0d: zero=%b result=%h expected 1 and 00000000", c, zero, result);
         end
      end
   endtask

   task automatic test_andn_xnor();
      run_op("andn", 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0, 1'b1);
      run_op("xnor", 3'b101, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      start = 1'b1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'h0F0F0F0F;
      exp_q.push_back(make_exp(3'b000, 32'hFFFFFFFF, 32'h0F0F0F0F));
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 6) begin
            op = 3'b001; a = 32'h00000001; b = 32'h80000000;
            exp_q.push_back(make_exp(3'b001, 32'h00000001, 32'h80000000));
         end else begin
            op = 3'($urandom); a = $urandom; b = $urandom;
         end
         if (c == 7) start = 1'b0;
         n_checks++;
         if (busy !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
            n_fail++;
            $display("FAIL b2b_busy_c%0d: got %b", c, busy);
         end
         n_checks++;
         if (done !== (c == 5 || c == 11)) begin
            n_fail++;
            $display("FAIL b2b_done_c%0d: got %b", c, done);
         end
         if (c == 5) begin
            n_checks++;
            if (result !== 32'h0F0F0F0F) begin
               n_fail++;
               $display("FAIL b2b_first_result: got %h expected 0f0f0f0f", result);
            end
         end
         if (c == 11) begin
            n_checks++;
            if (result !== 32'h80000001) begin
               n_fail++;
               $display("FAIL b2b_second_result: got %h expected 80000001", result);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      run_op("pre", 3'b010, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1'b0);
      start = 1'b1; op = 3'b001; a = 32'h12340000; b = 32'h00005678;
      exp_q.push_back(make_exp(3'b001, 32'h12340000, 32'h00005678));
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      n_checks++;
      if ({busy, done, zero, result} !== 35'h0) begin
         n_fail++;
         $display("FAIL midreset_state: busy=%b done=%b zero=%b result=%h expected all 0", busy, done, zero, result);
      end
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done !== 1'b0) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL midreset_no_done: got %0d done cycles expected 0", pulses);
      end
      run_op("post", 3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0);
   endtask

   task automatic test_wide_chunk();
      w_start = 1'b1; w_op = 3'b111; w_a = 32'h12345678; w_b = 32'hFFFFFFFF;
      wexp_q.push_back(make_exp(3'b111, 32'h12345678, 32'hFFFFFFFF));
      for (int c = 1; c <= 3; c++) begin
         tick();
         w_start = 1'b0; w_a = $urandom; w_b = $urandom; w_op = 3'($urandom);
         n_checks++;
         if (w_busy !== (c == 1)) begin
            n_fail++;
            $display("FAIL wide_busy_c%0d: got %b expected %b", c, w_busy, (c == 1));
         end
         n_checks++;
         if (w_done !== (c == 2)) begin
            n_fail++;
            $display("FAIL wide_done_c%0d: got %b expected %b", c, w_done, (c == 2));
         end
         if (c == 2) begin
            n_checks++;
            if (w_result !== 32'hEDCBA987 || w_zero !== 1'b0) begin
               n_fail++;
               $display("FAIL wide_result: got %h zero=%b expected edcba987 zero=0", w_result, w_zero);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_nor_latency();
      test_xor_zero();
      test_andn_xnor();
      test_back_to_back();
      test_reset_mid();
      test_wide_chunk();
      tick();
      n_checks++;
      if (exp_q.size() != 0 || wexp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d/%0d expected results never completed", exp_q.size(), wexp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
